lfsr16_prbs: RTL and testbench
==============================

Name: lfsr16_prbs

Overview:
- Free-running maximal-length Fibonacci LFSR that produces a pseudo-random word every clock.
- The default 16-bit configuration visits each of the 65535 nonzero 16-bit values exactly once per period.
- It serves as the shared pseudo-random source for stochastic and spike-generation logic.
- It has no data inputs; the state advances on every clock edge while out of reset.

Parameters:
- WIDTH, 16: register and output width; legal range 3..32.
- SEED, 1: state loaded on reset, truncated to WIDTH bits; must be nonzero (see lock-up rule).

Ports:
- clk    input   1      clock; the state advances on the rising edge.
- rst_n  input   1      asynchronous reset, active-HIGH despite the name; while 1, the state is forced to SEED.
- value  output  WIDTH  current LFSR state, driven directly from the state register (no combinational path).

Behaviour:
- State register S[WIDTH-1:0]; value = S at all times.
- Reset: when rst_n = 1, S = SEED immediately and asynchronously, with no wait for clk. While rst_n is held at 1, S stays at SEED.
- Advance: on each rising edge of clk with rst_n = 0, S <= {S[WIDTH-2:0], fb}, a left shift with feedback entering at the LSB.
- Feedback fb is the XOR of the tap bits; this is the XOR form, so the all-zero state is the lock-up state.
- WIDTH = 16 taps are polynomial x^16+x^15+x^13+x^4+1, i.e. fb = S[15]^S[14]^S[12]^S[3].
- Other widths: taps come from a compile-time lookup over WIDTH 3..32, using the standard maximal-length XOR tap set for each width (XAPP052 tap list, converted to 0-based bit indices).
- Elaboration must fail with a fatal error for WIDTH outside 3..32.
- Period is exactly 2^WIDTH - 1 cycles. After 2^WIDTH - 1 advances, S returns to SEED.
- Lock-up guard: if S is ever all-zero (SEED = 0, or an upset), the next edge loads 1 instead of shifting.
- Reset on the first edge after release: the first rising edge with rst_n = 0 produces the successor of SEED. There is no extra latency cycle.
- Reset mid-sequence: asserting rst_n at any point returns S to SEED and restarts the sequence from the beginning.
- No enable input; the register advances on every clock edge outside reset.

Test Plan:
- Reset: drive rst_n = 1 with no clock edge -> value = 0x0001 immediately. Hold rst_n = 1 for 5 edges -> value remains 0x0001.
- Sequence start (defaults): release reset and sample value after each edge -> 0x0002, 0x0004, 0x0008, 0x0011, 0x0022, 0x0044, 0x0088, 0x0111.
- Full-period uniqueness: keep a 65535-entry bitmap. Over 65535 consecutive clocked samples, no value repeats and 0x0000 never appears. Afterwards every entry 1..65535 is marked, and the next sample equals 0x0001.
- Mid-run reset: after 1000 edges, pulse rst_n high asynchronously between edges -> value = 0x0001 at once. After release, the sequence replays 0x0002, 0x0004, and so on.
- Lock-up guard: instantiate with SEED = 0 -> value = 0x0000 in reset; the first edge gives 0x0001 and the second gives 0x0002.
- Other width: WIDTH = 8, SEED = 1 -> period is exactly 255, all nonzero 8-bit values occur, and the state returns to 0x01 on cycle 255.

Source files
------------

// File: rtl/lfsr16_prbs.sv
// Free-running maximal-length Fibonacci LFSR (XOR form) used as a shared
// pseudo-random source; value is the state register itself.
module lfsr16_prbs #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned SEED  = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  output logic [WIDTH-1:0] value
);

  // Maximal-length XOR tap sets for widths 3..32, as 0-based bit masks.
  function automatic logic [31:0] tap_mask(input int unsigned w);
    logic [31:0] m;
    m = '0;
    case (w)
      3:       m = 32'h0000_0006;
      4:       m = 32'h0000_000C;
      5:       m = 32'h0000_0014;
      6:       m = 32'h0000_0030;
      7:       m = 32'h0000_0060;
      8:       m = 32'h0000_00B8;
      9:       m = 32'h0000_0110;
      10:      m = 32'h0000_0240;
      11:      m = 32'h0000_0500;
      12:      m = 32'h0000_0829;
      13:      m = 32'h0000_100D;
      14:      m = 32'h0000_2015;
      15:      m = 32'h0000_6000;
      16:      m = 32'h0000_D008;
      17:      m = 32'h0001_2000;
      18:      m = 32'h0002_0400;
      19:      m = 32'h0004_0023;
      20:      m = 32'h0009_0000;
      21:      m = 32'h0014_0000;
      22:      m = 32'h0030_0000;
      23:      m = 32'h0042_0000;
      24:      m = 32'h00E1_0000;
      25:      m = 32'h0120_0000;
      26:      m = 32'h0200_0023;
      27:      m = 32'h0400_0013;
      28:      m = 32'h0900_0000;
      29:      m = 32'h1400_0000;
      30:      m = 32'h2000_0029;
      31:      m = 32'h4800_0000;
      32:      m = 32'h8020_0003;
      default: m = '0;
    endcase
    return m;
  endfunction

  if (WIDTH < 3 || WIDTH > 32) begin : g_bad_width
    $fatal(1, "lfsr16_prbs: WIDTH %0d outside supported range 3..32", WIDTH);
  end

  localparam logic [31:0]      TAP_MASK  = tap_mask(WIDTH);
  localparam logic [WIDTH-1:0] TAPS      = TAP_MASK[WIDTH-1:0];
  localparam logic [WIDTH-1:0] SEED_BITS = WIDTH'(SEED);

  logic [WIDTH-1:0] state;
  logic [WIDTH-1:0] state_nxt;
  logic             fb;

  // Shift left with feedback at the LSB; all-zero lock-up recovers to 1.
  always_comb begin
    fb        = ^(state & TAPS);
    state_nxt = {state[WIDTH-2:0], fb};
    if (state == '0) begin
      state_nxt = WIDTH'(1);
    end
  end

  // rst_n is active-high here: asserting it loads SEED asynchronously.
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      state <= SEED_BITS;
    end else begin
      state <= state_nxt;
    end
  end

  assign value = state;

endmodule

// File: tb/tb_lfsr16_prbs.sv
// Directed bench for lfsr16_prbs: reset, sequence start, full period,
// mid-run reset, lock-up recovery and an 8-bit instance.
module tb_lfsr16_prbs;

  logic        clk;
  logic        rst_n;
  logic [15:0] value16;
  logic [15:0] value0;
  logic [7:0]  value8;

  int compared;
  int mismatched;

  bit seen16 [65536];
  bit seen8  [256];

  lfsr16_prbs u_dut16 (
    .clk   (clk),
    .rst_n (rst_n),
    .value (value16)
  );

  lfsr16_prbs #(.WIDTH(16), .SEED(0)) u_dut0 (
    .clk   (clk),
    .rst_n (rst_n),
    .value (value0)
  );

  lfsr16_prbs #(.WIDTH(8), .SEED(1)) u_dut8 (
    .clk   (clk),
    .rst_n (rst_n),
    .value (value8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    compared++;
    assert (observed === expected) else begin
      mismatched++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin : stim
    logic [15:0] seq16 [8];
    int dup16, dup8, marked16, marked8;

    seq16[0] = 16'h0002; seq16[1] = 16'h0004; seq16[2] = 16'h0008; seq16[3] = 16'h0011;
    seq16[4] = 16'h0022; seq16[5] = 16'h0044; seq16[6] = 16'h0088; seq16[7] = 16'h0111;
    compared   = 0;
    mismatched = 0;
    dup16 = 0; dup8 = 0; marked16 = 0; marked8 = 0;

    // Asynchronous reset with no clock edge.
    rst_n = 1'b0;
    #1 rst_n = 1'b1;
    #1;
    check("reset_async16", 32'(value16), 32'h0001);
    check("reset_async0",  32'(value0),  32'h0000);
    check("reset_async8",  32'(value8),  32'h01);

    // Reset held across edges.
    for (int i = 0; i < 5; i++) begin
      tick();
      check("reset_hold16", 32'(value16), 32'h0001);
    end
    check("reset_hold0", 32'(value0), 32'h0000);

    rst_n = 1'b0;
    #1;
    check("release16", 32'(value16), 32'h0001);

    // Sample before each edge; 65535 samples then the state wraps to SEED.
    for (int i = 0; i < 65535; i++) begin
      if (seen16[value16] || value16 == 16'h0000) dup16++;
      seen16[value16] = 1'b1;
      if (i < 255) begin
        if (seen8[value8] || value8 == 8'h00) dup8++;
        seen8[value8] = 1'b1;
      end
      if (i == 255) check("wrap8", 32'(value8), 32'h01);
      if (i >= 1 && i <= 8) check("seq16", 32'(value16), 32'(seq16[i-1]));
      if (i == 1) check("lockup_first", 32'(value0), 32'h0001);
      if (i == 2) check("lockup_second", 32'(value0), 32'h0002);
      tick();
    end
    check("wrap16", 32'(value16), 32'h0001);
    check("dup16", 32'(dup16), 32'd0);
    check("dup8", 32'(dup8), 32'd0);
    for (int v = 1; v < 65536; v++) if (seen16[v]) marked16++;
    for (int v = 1; v < 256; v++) if (seen8[v]) marked8++;
    check("marked16", 32'(marked16), 32'd65535);
    check("marked8", 32'(marked8), 32'd255);
    check("zero_seen16", 32'(seen16[0]), 32'd0);

    // Mid-run asynchronous reset pulse between edges.
    for (int i = 0; i < 1000; i++) tick();
    #2 rst_n = 1'b1;
    #1;
    check("midreset16", 32'(value16), 32'h0001);
    check("midreset0",  32'(value0),  32'h0000);
    check("midreset8",  32'(value8),  32'h01);
    #1 rst_n = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("replay16", 32'(value16), 32'(seq16[i]));
    end
    check("replay8", 32'(value8), 32'h11);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
